// File: rtl/addr_window_map.sv
// rtl/addr_window_map.sv - programmable address window decoder with double-buffered config
// Optional hit counters are built when ADDR_WINDOW_HITCOUNT_EN is defined.
module addr_window_map #(
  parameter int NUM_WIN = 8,
  parameter int ADDR_W  = 24,
  parameter int IDX_W   = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] SNES_ADDR,
  input  logic              SNES_ACCESS,
  input  logic              bus_idle,
  input  logic              map_unlock,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [2:0]        cfg_sel,
  input  logic [ADDR_W-1:0] cfg_data,
  input  logic              cfg_commit,
  output logic              cfg_busy,
  output logic [ADDR_W-1:0] ROM_ADDR,
  output logic              ROM_HIT,
  output logic              IS_WRITABLE,
  output logic              IS_SAVERAM,
  output logic [IDX_W-1:0]  hit_idx,
  input  logic [IDX_W-1:0]  cnt_idx,
  input  logic              cnt_clr,
  output logic [15:0]       cnt_data
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_APPLY   = 2'd2
  } state_t;

  localparam logic [2:0] SEL_BASE   = 3'd0;
  localparam logic [2:0] SEL_MMASK  = 3'd1;
  localparam logic [2:0] SEL_OMASK  = 3'd2;
  localparam logic [2:0] SEL_TARGET = 3'd3;
  localparam logic [2:0] SEL_FLAGS  = 3'd4;

  // flags bit positions: {saveram, writable, enable}
  localparam int FL_EN  = 0;
  localparam int FL_WR  = 1;
  localparam int FL_SR  = 2;

  state_t state;

  // Shadow set, written by the MCU
  logic [ADDR_W-1:0] sh_base   [NUM_WIN];
  logic [ADDR_W-1:0] sh_mmask  [NUM_WIN];
  logic [ADDR_W-1:0] sh_omask  [NUM_WIN];
  logic [ADDR_W-1:0] sh_target [NUM_WIN];
  logic [2:0]        sh_flags  [NUM_WIN];

  // Active set, used by the decoder
  logic [ADDR_W-1:0] act_base   [NUM_WIN];
  logic [ADDR_W-1:0] act_mmask  [NUM_WIN];
  logic [ADDR_W-1:0] act_omask  [NUM_WIN];
  logic [ADDR_W-1:0] act_target [NUM_WIN];
  logic [2:0]        act_flags  [NUM_WIN];

  logic              win_hit;
  logic [IDX_W-1:0]  win_idx;
  logic [ADDR_W-1:0] win_addr;
  logic              idx_ok;

  assign idx_ok = (int'(cfg_idx) < NUM_WIN);

  // Shadow register writes; dropped while a commit is outstanding
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        sh_base[i]   <= '0;
        sh_mmask[i]  <= '0;
        sh_omask[i]  <= '0;
        sh_target[i] <= '0;
        sh_flags[i]  <= '0;
      end
    end else if (cfg_we && !cfg_busy && idx_ok) begin
      case (cfg_sel)
        SEL_BASE:   sh_base[cfg_idx]   <= cfg_data;
        SEL_MMASK:  sh_mmask[cfg_idx]  <= cfg_data;
        SEL_OMASK:  sh_omask[cfg_idx]  <= cfg_data;
        SEL_TARGET: sh_target[cfg_idx] <= cfg_data;
        SEL_FLAGS:  sh_flags[cfg_idx]  <= cfg_data[2:0];
        default:    ;
      endcase
    end
  end

  // Commit sequencer: wait for an idle bus, then apply for exactly one cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      cfg_busy <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_commit) begin
            state    <= ST_PENDING;
            cfg_busy <= 1'b1;
          end
        end
        ST_PENDING: begin
          if (bus_idle) begin
            state <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          state    <= ST_IDLE;
          cfg_busy <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          cfg_busy <= 1'b0;
        end
      endcase
    end
  end

  // Atomic shadow-to-active copy at the end of the apply cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        act_base[i]   <= '0;
        act_mmask[i]  <= '0;
        act_omask[i]  <= '0;
        act_target[i] <= '0;
        act_flags[i]  <= '0;
      end
    end else if (state == ST_APPLY) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        act_base[i]   <= sh_base[i];
        act_mmask[i]  <= sh_mmask[i];
        act_omask[i]  <= sh_omask[i];
        act_target[i] <= sh_target[i];
        act_flags[i]  <= sh_flags[i];
      end
    end
  end

  // Priority match: scanning downwards leaves the lowest matching index
  always_comb begin
    win_hit = 1'b0;
    win_idx = '0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (act_flags[i][FL_EN] &&
          ((SNES_ADDR & act_mmask[i]) == (act_base[i] & act_mmask[i]))) begin
        win_hit = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end

  // Translation wraps modulo 2^ADDR_W since the sum keeps only ADDR_W bits
  always_comb begin
    win_addr = act_target[win_idx] + (SNES_ADDR & act_omask[win_idx]);
  end

  // Registered decode outputs; all zero when nothing matches
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ROM_ADDR    <= '0;
      ROM_HIT     <= 1'b0;
      IS_WRITABLE <= 1'b0;
      IS_SAVERAM  <= 1'b0;
      hit_idx     <= '0;
    end else if (win_hit) begin
      ROM_ADDR    <= win_addr;
      ROM_HIT     <= 1'b1;
      IS_WRITABLE <= act_flags[win_idx][FL_WR] | map_unlock;
      IS_SAVERAM  <= act_flags[win_idx][FL_SR];
      hit_idx     <= win_idx;
    end else begin
      ROM_ADDR    <= '0;
      ROM_HIT     <= 1'b0;
      IS_WRITABLE <= 1'b0;
      IS_SAVERAM  <= 1'b0;
      hit_idx     <= '0;
    end
  end

`ifdef ADDR_WINDOW_HITCOUNT_EN
  logic [15:0] hit_cnt [NUM_WIN];

  // Saturating per-window access counters; clear beats increment
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        hit_cnt[i] <= '0;
      end
    end else if (cnt_clr) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        hit_cnt[i] <= '0;
      end
    end else if (SNES_ACCESS && win_hit && (hit_cnt[win_idx] != 16'hFFFF)) begin
      hit_cnt[win_idx] <= hit_cnt[win_idx] + 16'd1;
    end
  end

  // Registered counter readback
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_data <= '0;
    end else if (int'(cnt_idx) < NUM_WIN) begin
      cnt_data <= hit_cnt[cnt_idx];
    end else begin
      cnt_data <= '0;
    end
  end
`else
  logic unused_cnt;

  assign unused_cnt = ^{SNES_ACCESS, cnt_clr, cnt_idx};
  assign cnt_data   = '0;
`endif

endmodule
